fpu_result_stage: RTL and testbench
===================================

// Module: fpu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the combinational FP multiplier.
//  Accepts {resultMul, errorMul, overflowMul} words via valid/ready into a small FIFO.
//  Presents them to the consumer (register file / bus) via valid/ready.
//  Keeps IEEE-style sticky status flags and a saturating count of delivered results.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of two, >= 2
//  CNT_W  16  width of op_count
// PORTS
//  clk          in   1      rising-edge clock; the only clock
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      multiplier word valid
//  in_ready     out  1      stage can accept a word this cycle
//  in_result    in   32     multiplier result (IEEE-754 single)
//  in_error     in   1      multiplier errorMul
//  in_overflow  in   1      multiplier overflowMul
//  out_valid    out  1      head entry valid
//  out_ready    in   1      consumer takes head entry
//  out_result   out  32     head entry result
//  out_error    out  1      head entry error bit
//  out_overflow out  1      head entry overflow bit
//  flag_clear   in   1      clear all sticky flags
//  flag_invalid out  1      sticky: a NaN result was accepted
//  flag_ovf     out  1      sticky: an overflow word was accepted
//  flag_zero    out  1      sticky: a +/-0 result was accepted
//  op_count     out  CNT_W  delivered results, saturating
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): FIFO emptied; out_valid=0; out_result=0; out_error=0;
//    out_overflow=0; all flags=0; op_count=0. in_ready=1 in the first cycle after reset.
//  - Storage: circular buffer of DEPTH x 34 bits {overflow, error, result}.
//    Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//    Occupancy counter is log2(DEPTH)+1 bits.
//  - in_ready = (occupancy != DEPTH). It is registered-state only; it never depends on out_ready.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - out_valid = (occupancy != 0). out_* show the head entry. out_* are 0 when the FIFO is empty.
//  - Latency: a word pushed at edge N appears on out_* after edge N. Minimum 1 cycle; no bypass.
//  - Simultaneous push and pop when 0 < occupancy < DEPTH: both occur; occupancy is unchanged.
//  - Full: in_ready=0, so a pop in that cycle is the only event. in_ready returns to 1 the next cycle.
//  - Empty: no pop is possible, regardless of out_ready.
//  - out_valid/out_* stay stable while out_valid & !out_ready. A word is never dropped or duplicated.
//  - Sticky flags update on push only, from the incoming word:
//      flag_invalid |= (in_result[30:23]==8'hFF) & (in_result[22:0]!=0)
//      flag_ovf     |= in_overflow
//      flag_zero    |= (in_result[30:0]==0)
//  - flag_clear clears all flags. If flag_clear and a flag-setting push occur in the same cycle,
//    the set wins and only that word's flags remain set.
//  - op_count += 1 on each pop. It saturates at 2^CNT_W-1 and does not wrap.
//  - rst asserted mid-operation discards all stored entries; no out_valid pulse follows.
//  - Upstream rule: in_result/in_error/in_overflow are sampled only when push=1.
// TESTING
//  1 Reset then idle -> out_valid=0, in_ready=1, flags=0, op_count=0.
//  2 Push 32'h40C00000 (6.0). Hold out_ready=1.
//    -> out_valid=1 one cycle later with out_result=32'h40C00000; op_count=1 after the pop.
//  3 Hold out_ready=0 and push 5 words (DEPTH=4).
//    -> in_ready=0 after the 4th push; the 5th word is held upstream.
//    Then pop all -> order is preserved and the 5th word is accepted once space frees.
//  4 Push {32'h7FC00000, err=1, ovf=0} -> flag_invalid=1.
//    Push {32'h7F800000, err=1, ovf=1} -> flag_ovf=1.
//    Push 32'h80000000 -> flag_zero=1.
//  5 flag_clear=1 in the same cycle as pushing 32'h7FC00000, err=1
//    -> next cycle flag_invalid=1, flag_ovf=0, flag_zero=0.
//  6 With CNT_W=4, pop 20 words -> op_count stops at 15.
//    Assert rst with 3 entries queued -> out_valid=0 next cycle and op_count=0.

Source files
------------

// File: rtl/fpu_result_stage.sv
// Registered output stage for the FP multiplier: a DEPTH-entry FIFO with valid/ready
// on both sides, sticky IEEE-style status flags and a saturating delivered-result count.
module fpu_result_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_error,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_error,
    output logic             out_overflow,
    input  logic             flag_clear,
    output logic             flag_invalid,
    output logic             flag_ovf,
    output logic             flag_zero,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   OCC_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   OCC_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [33:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_occ;
    logic [2:0]       r_flags;
    logic [CNT_W-1:0] r_cnt;

    logic        w_push, w_pop;
    logic [33:0] w_head;
    logic [2:0]  w_set;

    assign in_ready  = (r_occ != OCC_FULL);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_head    = out_valid ? r_mem[r_rptr] : 34'd0;

    assign out_result   = w_head[31:0];
    assign out_error    = w_head[32];
    assign out_overflow = w_head[33];

    // Flag bits: {zero, ovf, invalid}, derived from the incoming word only.
    assign w_set[0] = (in_result[30:23] == 8'hFF) && (in_result[22:0] != 23'd0);
    assign w_set[1] = in_overflow;
    assign w_set[2] = (in_result[30:0] == 31'd0);

    assign flag_invalid = r_flags[0];
    assign flag_ovf     = r_flags[1];
    assign flag_zero    = r_flags[2];
    assign op_count     = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {in_overflow, in_error, in_result};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop)      r_occ <= r_occ + OCC_ONE;
            else if (w_pop && !w_push) r_occ <= r_occ - OCC_ONE;
            // A clear coinciding with a push leaves exactly that word's flags.
            r_flags <= (flag_clear ? 3'b000 : r_flags) | (w_push ? w_set : 3'b000);
            if (w_pop && (r_cnt != '1)) r_cnt <= r_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_fpu_result_stage.sv
// Bench for fpu_result_stage: directed steps plus random traffic, checked against a
// queue-based reference model of the FIFO, flags and saturating counter.
module tb_fpu_result_stage;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_error, in_overflow;
    logic [31:0] in_result, out_result;
    logic out_valid, out_ready, out_error, out_overflow;
    logic flag_clear, flag_invalid, flag_ovf, flag_zero;
    logic [CNT_W-1:0] op_count;

    fpu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_error(in_error), .in_overflow(in_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_overflow(out_overflow), .flag_clear(flag_clear),
        .flag_invalid(flag_invalid), .flag_ovf(flag_ovf), .flag_zero(flag_zero),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model
    logic [33:0] m_q[$];
    bit m_inv, m_ovf, m_zero;
    int m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [33:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 34'd0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < DEPTH});
        chk("out_result", out_result, h[31:0]);
        chk("out_err_ovf", {30'd0, out_overflow, out_error}, {30'd0, h[33], h[32]});
        chk("flags", {29'd0, flag_zero, flag_ovf, flag_invalid}, {29'd0, m_zero, m_ovf, m_inv});
        chk("op_count", {{(32-CNT_W){1'b0}}, op_count}, m_cnt);
    endtask

    function automatic bit is_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 0);
    endfunction

    // One clock: inputs applied at the falling edge, model advanced, outputs checked
    // at the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] res, input bit err, input bit ovf,
                         input bit ordy, input bit clr);
        bit push, pop;
        in_valid = v; in_result = res; in_error = err; in_overflow = ovf;
        out_ready = ordy; flag_clear = clr;
        push = v && (m_q.size() < DEPTH);
        pop  = ordy && (m_q.size() > 0);
        @(posedge clk);
        if (clr) begin m_inv = 0; m_ovf = 0; m_zero = 0; end
        if (pop) begin
            void'(m_q.pop_front());
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (push) begin
            m_q.push_back({ovf, err, res});
            if (is_nan(res)) m_inv = 1;
            if (ovf) m_ovf = 1;
            if (res[30:0] == 0) m_zero = 1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 32'h0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0: return 32'h7FC00000 | $urandom_range(0, 1023);
            1: return {$urandom_range(0, 1) == 1, 31'd0};
            2: return 32'h7F800000;
            default: return $urandom;
        endcase
    endfunction

    // Reset inside cycle() must clear the model too; wrap it here.
    task automatic reset_model();
        m_q.delete(); m_inv = 0; m_ovf = 0; m_zero = 0; m_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_result = 0; in_error = 0; in_overflow = 0;
        out_ready = 0; flag_clear = 0;
        reset_model();
        @(negedge clk);

        // 1: reset then idle
        do_reset(); reset_model(); check_all();
        cycle(0, 0, 0, 0, 0, 0);

        // 2: single word, consumer ready
        cycle(1, 32'h40C00000, 0, 0, 1, 0);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_result", out_result, 32'h40C00000);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t2_count", {28'd0, op_count}, 32'd1);

        // 3: fill with consumer stalled, then drain while the 5th word waits upstream
        for (int i = 0; i < 4; i++) cycle(1, 32'h3F800000 + i, 0, 0, 0, 0);
        chk("t3_full", {31'd0, in_ready}, 32'd0);
        cycle(1, 32'h3F800004, 0, 0, 0, 0);
        chk("t3_hold", out_result, 32'h3F800000);
        cycle(1, 32'h3F800004, 0, 0, 1, 0);
        chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) cycle(i == 0, 32'h3F800004, 0, 0, 1, 0);
        chk("t3_empty", {31'd0, out_valid}, 32'd0);

        // 4: flag setting
        cycle(1, 32'h7FC00000, 1, 0, 1, 0);
        cycle(1, 32'h7F800000, 1, 1, 1, 0);
        cycle(1, 32'h80000000, 0, 0, 1, 0);
        chk("t4_flags", {29'd0, flag_zero, flag_ovf, flag_invalid}, 32'd7);

        // 5: clear concurrent with a NaN push
        cycle(1, 32'h7FC00000, 1, 0, 1, 1);
        chk("t5_flags", {29'd0, flag_zero, flag_ovf, flag_invalid}, 32'd1);
        cycle(0, 0, 0, 0, 1, 1);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rnd_word(), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

        // 6: saturation, then reset with 3 entries queued
        for (int i = 0; i < 20; i++) cycle(1, $urandom, 0, 0, 1, 0);
        chk("t6_sat", {28'd0, op_count}, CNT_MAX);
        for (int i = 0; i < 3; i++) cycle(1, 32'h12345678 + i, 0, 0, 0, 0);
        chk("t6_queued", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        in_valid = 0; out_ready = 1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        reset_model(); check_all();
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_count", {28'd0, op_count}, 32'd0);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t6_no_pulse", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
